// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host-side control and SPI pin bundle for spi_master
interface spi_master_if #(
  parameter int WORD_SIZE = 8
);
  logic                 start;
  logic [WORD_SIZE-1:0] tx_data;
  logic                 busy;
  logic [WORD_SIZE-1:0] rx_data;
  logic                 rx_valid;
  logic                 sclk;
  logic                 cs_n;
  logic                 mosi;
  logic                 miso;

  modport master (
    input  start, tx_data, miso,
    output busy, rx_data, rx_valid, sclk, cs_n, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, rx_data, rx_valid, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 word master, MSB first, registered pin outputs
// Optional back-to-back words in one cs_n frame: define SPI_MASTER_BURST_EN.
module spi_master #(
  parameter int WORD_SIZE = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(WORD_SIZE + 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER_LO, XFER_HI, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [WORD_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_SIZE-1:0] rx_data_q, rx_data_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tick;

  assign tick         = (div_q == DW'(CLK_DIV - 1));
  assign bus.sclk     = sclk_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.mosi     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = (state_q == IDLE || tick) ? '0 : div_q + DW'(1);
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_shift_d = bus.tx_data;
          mosi_d     = bus.tx_data[WORD_SIZE-1];
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (tick) state_d = XFER_LO;
      end
      XFER_LO: begin
        // miso is captured on the same edge that raises sclk
        if (tick) begin
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[WORD_SIZE-2:0], bus.miso};
          state_d    = XFER_HI;
        end
      end
      XFER_HI: begin
        if (tick) begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(WORD_SIZE - 1)) begin
            state_d = HOLD;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            mosi_d     = tx_shift_q[WORD_SIZE-2];
            state_d    = XFER_LO;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
`ifdef SPI_MASTER_BURST_EN
          if (bus.start) begin
            tx_shift_d = bus.tx_data;
            mosi_d     = bus.tx_data[WORD_SIZE-1];
            bit_cnt_d  = '0;
            state_d    = XFER_LO;
          end else begin
            cs_n_d  = 1'b1;
            state_d = GAP;
          end
`else
          cs_n_d  = 1'b1;
          state_d = GAP;
`endif
        end
      end
      GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
